// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types for the CPU-domain reset sequencer.
// States, cause codes and counter sizing helpers.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SYS_HOLD,
    PERIPH_HOLD,
    RUN
  } state_t;

  localparam logic [1:0] CAUSE_POWER  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK   = 2'b01;
  localparam logic [1:0] CAUSE_BUTTON = 2'b10;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: async board inputs and staged reset outputs.
// master = sequencer, slave = board/consumers.
interface reset_sequencer_if;

  logic       pll_locked;
  logic       btn_reset;
  logic       sys_reset;
  logic       periph_reset;
  logic       ready;
  logic [1:0] reset_cause;
  logic [7:0] lock_loss_count;

  modport master (
    input  pll_locked,
    input  btn_reset,
    output sys_reset,
    output periph_reset,
    output ready,
    output reset_cause,
    output lock_loss_count
  );

  modport slave (
    output pll_locked,
    output btn_reset,
    input  sys_reset,
    input  periph_reset,
    input  ready,
    input  reset_cause,
    input  lock_loss_count
  );

endinterface

// File: rtl/sync_debounce.sv
// sync_debounce: N-flop synchroniser plus optional press qualifier.
// DEBOUNCE_CYCLES=0 yields a level-only synchroniser.
module sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clock,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign level = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES > 0) begin : g_deb
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
      localparam logic [CW-1:0] FULL = CW'(DEBOUNCE_CYCLES);

      logic [CW-1:0] cnt_q;
      logic          press_q;

      // count parks at FULL so a held button fires once
      always_ff @(posedge clock) begin
        if (!resetn) begin
          cnt_q   <= '0;
          press_q <= 1'b0;
        end else begin
          press_q <= level && (cnt_q == LAST);
          if (!level) begin
            cnt_q <= '0;
          end else if (cnt_q != FULL) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end

      assign press = press_q;
    end else begin : g_lvl
      assign press = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: PLL-lock / button driven staged reset release.
// Core reset drops first, peripheral reset later, cause recorded.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int SYS_HOLD_CYCLES     = 16,
  parameter int PERIPH_DELAY_CYCLES = 16,
  parameter int DEBOUNCE_CYCLES     = 65536
) (
  input  logic               clock,
  input  logic               resetn,
  reset_sequencer_if.master  bus
);

  localparam int MAXC = max3(LOCK_STABLE_CYCLES,
                             SYS_HOLD_CYCLES,
                             PERIPH_DELAY_CYCLES);
  localparam int CW = cnt_width(MAXC);

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] SYS_LAST  = CW'(SYS_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] PER_LAST  = CW'(PERIPH_DELAY_CYCLES - 1);

  logic locked_s;
  logic lock_press_unused;
  logic btn_s_unused;
  logic btn_press;

  sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (0)
  ) u_lock (
    .clock  (clock),
    .resetn (resetn),
    .din    (bus.pll_locked),
    .level  (locked_s),
    .press  (lock_press_unused)
  );

  sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clock  (clock),
    .resetn (resetn),
    .din    (bus.btn_reset),
    .level  (btn_s_unused),
    .press  (btn_press)
  );

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          sys_q, sys_n;
  logic          per_q, per_n;
  logic          rdy_q, rdy_n;
  logic [1:0]    cause_q, cause_n;
  logic [7:0]    llc_q, llc_n;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      sys_q   <= 1'b1;
      per_q   <= 1'b1;
      rdy_q   <= 1'b0;
      cause_q <= CAUSE_POWER;
      llc_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      sys_q   <= sys_n;
      per_q   <= per_n;
      rdy_q   <= rdy_n;
      cause_q <= cause_n;
      llc_q   <= llc_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    sys_n   = sys_q;
    per_n   = per_q;
    rdy_n   = rdy_q;
    cause_n = cause_q;
    llc_n   = llc_q;

    if (state_q == WAIT_LOCK) begin
      sys_n = 1'b1;
      per_n = 1'b1;
      rdy_n = 1'b0;
      if (btn_press) begin
        cnt_n   = '0;
        cause_n = CAUSE_BUTTON;
      end else if (!locked_s) begin
        cnt_n = '0;
      end else if (cnt_q == LOCK_LAST) begin
        state_n = SYS_HOLD;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt_q + 1'b1;
      end
    end else if (!locked_s || btn_press) begin
      // lock loss takes priority over a coincident press
      state_n = WAIT_LOCK;
      cnt_n   = '0;
      sys_n   = 1'b1;
      per_n   = 1'b1;
      rdy_n   = 1'b0;
      if (!locked_s) begin
        cause_n = CAUSE_LOCK;
        if (llc_q != 8'hFF) llc_n = llc_q + 8'd1;
      end else begin
        cause_n = CAUSE_BUTTON;
      end
    end else begin
      unique case (state_q)
        SYS_HOLD: begin
          if (cnt_q == SYS_LAST) begin
            state_n = PERIPH_HOLD;
            cnt_n   = '0;
            sys_n   = 1'b0;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        PERIPH_HOLD: begin
          if (cnt_q == PER_LAST) begin
            state_n = RUN;
            cnt_n   = '0;
            per_n   = 1'b0;
            rdy_n   = 1'b1;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_n = cnt_q;
        end
      endcase
    end
  end

  assign bus.sys_reset       = sys_q;
  assign bus.periph_reset    = per_q;
  assign bus.ready           = rdy_q;
  assign bus.reset_cause     = cause_q;
  assign bus.lock_loss_count = llc_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed + random stimulus against a
// phase-count reference model of the reset sequence.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int SYNC = 2;
  localparam int L    = 8;
  localparam int S    = 4;
  localparam int P    = 4;
  localparam int DEB  = 5;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  reset_sequencer_if bus();

  reset_sequencer #(
    .SYNC_STAGES         (SYNC),
    .LOCK_STABLE_CYCLES  (L),
    .SYS_HOLD_CYCLES     (S),
    .PERIPH_DELAY_CYCLES (P),
    .DEBOUNCE_CYCLES     (DEB)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // n = consecutive good cycles since the sequence last restarted
  bit lh[SYNC];
  bit bh[SYNC];
  int brun;
  bit pend;
  int n;
  int m_cause;
  int m_llc;
  int edge_no;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit ls, bs, press;
    if (!resetn) begin
      for (int i = 0; i < SYNC; i++) begin
        lh[i] = 1'b0;
        bh[i] = 1'b0;
      end
      brun    = 0;
      pend    = 1'b0;
      n       = 0;
      m_cause = 0;
      m_llc   = 0;
    end else begin
      ls    = lh[SYNC-1];
      bs    = bh[SYNC-1];
      press = pend;
      for (int i = SYNC - 1; i > 0; i--) begin
        lh[i] = lh[i-1];
        bh[i] = bh[i-1];
      end
      lh[0] = bus.pll_locked;
      bh[0] = bus.btn_reset;
      brun  = bs ? ((brun < 1000) ? brun + 1 : brun) : 0;
      pend  = (brun == DEB);
      if (n < L) begin
        if (press) begin
          n       = 0;
          m_cause = 2;
        end else if (!ls) begin
          n = 0;
        end else begin
          n++;
        end
      end else begin
        if (!ls) begin
          n       = 0;
          m_cause = 1;
          if (m_llc < 255) m_llc++;
        end else if (press) begin
          n       = 0;
          m_cause = 2;
        end else if (n < L + S + P) begin
          n++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    edge_no++;
    #1;
    check("sys",    bus.sys_reset,       n < L + S);
    check("periph", bus.periph_reset,    n < L + S + P);
    check("ready",  bus.ready,           n >= L + S + P);
    check("cause",  bus.reset_cause,     m_cause);
    check("count",  bus.lock_loss_count, m_llc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int aborts;
    int guard;
    bit prev;

    bus.pll_locked = 1'b1;
    bus.btn_reset  = 1'b0;
    resetn = 1'b0;
    edge_no = 0;

    // clean power-up
    repeat (3) tick();
    check("rst_sys",   bus.sys_reset, 1);
    check("rst_per",   bus.periph_reset, 1);
    check("rst_rdy",   bus.ready, 0);
    check("rst_cause", bus.reset_cause, CAUSE_POWER);
    check("rst_cnt",   bus.lock_loss_count, 0);
    resetn = 1'b1;
    edge_no = 0;
    repeat (13) tick();
    check("sys_e13", bus.sys_reset, 1);
    tick();
    check("sys_e14", bus.sys_reset, 0);
    check("per_e14", bus.periph_reset, 1);
    repeat (3) tick();
    check("rdy_e17", bus.ready, 0);
    tick();
    check("rdy_e18", bus.ready, 1);
    check("per_e18", bus.periph_reset, 0);
    check("cause_pu", bus.reset_cause, CAUSE_POWER);

    // one-cycle lock glitch while counting
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    edge_no = 0;
    repeat (6) tick();
    bus.pll_locked = 1'b0;
    tick();
    bus.pll_locked = 1'b1;
    repeat (13) tick();
    check("glitch_sys_e20", bus.sys_reset, 1);
    tick();
    check("glitch_sys_e21", bus.sys_reset, 0);
    repeat (4) tick();
    check("glitch_rdy_e25", bus.ready, 1);
    check("glitch_cause", bus.reset_cause, CAUSE_POWER);
    check("glitch_cnt", bus.lock_loss_count, 0);

    // lock loss in RUN
    bus.pll_locked = 1'b0;
    repeat (2) tick();
    check("ll_sys_e2", bus.sys_reset, 0);
    tick();
    check("ll_sys_e3", bus.sys_reset, 1);
    check("ll_rdy_e3", bus.ready, 0);
    check("ll_cause", bus.reset_cause, CAUSE_LOCK);
    check("ll_cnt", bus.lock_loss_count, 1);
    bus.pll_locked = 1'b1;
    repeat (25) tick();
    check("ll_relock", bus.ready, 1);

    // bouncing button
    bus.btn_reset = 1'b1;
    repeat (3) tick();
    bus.btn_reset = 1'b0;
    repeat (12) tick();
    check("bounce_ign", bus.ready, 1);
    bus.btn_reset = 1'b1;
    repeat (6) tick();
    bus.btn_reset = 1'b0;
    tick();
    check("btn_e7", bus.ready, 1);
    tick();
    check("btn_e8", bus.ready, 0);
    check("btn_cause", bus.reset_cause, CAUSE_BUTTON);
    repeat (25) tick();
    check("btn_rerun", bus.ready, 1);

    // held button gives one abort
    aborts = 0;
    bus.btn_reset = 1'b1;
    repeat (40) begin
      prev = bus.ready;
      tick();
      if (prev && !bus.ready) aborts++;
    end
    check("held_aborts", aborts, 1);
    check("held_rdy", bus.ready, 1);
    bus.btn_reset = 1'b0;
    repeat (4) tick();

    // lock loss and press qualify on the same edge
    bus.btn_reset = 1'b1;
    repeat (5) tick();
    bus.pll_locked = 1'b0;
    repeat (3) tick();
    check("sim_cause", bus.reset_cause, CAUSE_LOCK);
    check("sim_cnt", bus.lock_loss_count, 2);
    check("sim_sys", bus.sys_reset, 1);
    bus.btn_reset = 1'b0;
    bus.pll_locked = 1'b1;
    repeat (25) tick();

    // random lock drops and button chatter
    repeat (600) begin
      bus.pll_locked = ($urandom_range(0, 99) < 97);
      if ($urandom_range(0, 19) == 0)
        bus.btn_reset = ~bus.btn_reset;
      tick();
    end
    bus.btn_reset = 1'b0;
    bus.pll_locked = 1'b1;
    repeat (4) tick();

    // saturation of the lock-loss counter
    for (int ev = 0; ev < 260; ev++) begin
      bus.pll_locked = 1'b1;
      guard = 0;
      while (n < L && guard < 60) begin
        tick();
        guard++;
      end
      if (guard >= 60) check("sat_timeout", guard, 0);
      bus.pll_locked = 1'b0;
      repeat (3) tick();
    end
    check("sat_cnt", bus.lock_loss_count, 255);
    check("sat_cause", bus.reset_cause, CAUSE_LOCK);

    // resetn mid SYS_HOLD
    bus.pll_locked = 1'b1;
    guard = 0;
    while (n != L + 1 && guard < 60) begin
      tick();
      guard++;
    end
    if (guard >= 60) check("hold_timeout", guard, 0);
    resetn = 1'b0;
    tick();
    check("ovr_sys", bus.sys_reset, 1);
    check("ovr_per", bus.periph_reset, 1);
    check("ovr_rdy", bus.ready, 0);
    check("ovr_cause", bus.reset_cause, CAUSE_POWER);
    check("ovr_cnt", bus.lock_loss_count, 0);
    resetn = 1'b1;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Power-up and reset sequencer for the CPU clock domain, sitting directly downstream of the board PLL. It synchronises the PLL `locked` flag and the board reset button into `clock` (the 50 MHz CPU clock output of the PLL). It then releases a staged pair of resets: core reset first, peripheral reset later. Any loss of lock or debounced button press re-enters the sequence and records the cause.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of each input synchroniser (minimum 2).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronised-locked cycles required before sequencing starts.
- `SYS_HOLD_CYCLES`, 16: cycles `sys_reset` stays asserted after lock is declared stable.
- `PERIPH_DELAY_CYCLES`, 16: extra cycles `periph_reset` stays asserted after `sys_reset` falls.
- `DEBOUNCE_CYCLES`, 65536: consecutive synchronised-high cycles that qualify a button press.

Ports:
- `clock` in 1: CPU clock, sourced from the PLL primary output.
- `resetn` in 1: synchronous, active-low reset.
- `pll_locked` in 1: PLL lock flag, asynchronous to `clock`.
- `btn_reset` in 1: board reset button, active-high, asynchronous, bouncy.
- `sys_reset` out 1: active-high synchronous reset for the CPU and decoder.
- `periph_reset` out 1: active-high synchronous reset for video, GPU and I/O.
- `ready` out 1: high only in RUN.
- `reset_cause` out 2: cause code. 00 = power-on/`resetn`, 01 = lock lost, 10 = button.
- `lock_loss_count` out 8: saturating count of lock-loss events since `resetn`.

## Operation
- All outputs are registered.
- While `resetn`=0, on each edge:
  - state=WAIT_LOCK, counter=0, synchroniser and debounce flops=0;
  - `sys_reset`=1, `periph_reset`=1, `ready`=0, `reset_cause`=00, `lock_loss_count`=0.
- `locked_s` is the output of the `SYNC_STAGES`-deep synchroniser on `pll_locked`.
- `btn_press` is a one-cycle pulse generated when synchronised `btn_reset` has been high for `DEBOUNCE_CYCLES` consecutive cycles.
  - The button must return low, for any duration, before it can produce another pulse.
- States and transitions:
  - WAIT_LOCK: `sys_reset`=1, `periph_reset`=1.
    - Counter increments each cycle `locked_s`=1 and clears to 0 when `locked_s`=0.
    - When counter reaches `LOCK_STABLE_CYCLES`-1 with `locked_s`=1, go to SYS_HOLD and clear the counter.
  - SYS_HOLD: both resets stay 1. After `SYS_HOLD_CYCLES` cycles go to PERIPH_HOLD; `sys_reset`←0.
  - PERIPH_HOLD: `sys_reset`=0, `periph_reset`=1. After `PERIPH_DELAY_CYCLES` cycles go to RUN; `periph_reset`←0, `ready`←1.
  - RUN: all resets 0, `ready`=1.
- Abort, in any state other than WAIT_LOCK:
  - Triggered by `locked_s`=0 or `btn_press`=1.
  - Next edge: state=WAIT_LOCK, counter=0, `sys_reset`=1, `periph_reset`=1, `ready`=0.
  - `reset_cause` is set to 01 (lock lost) or 10 (button).
  - `lock_loss_count` increments on lock-lost aborts only, saturating at 255.
- Simultaneous lock loss and button press: lock loss wins (cause=01, count increments).
- In WAIT_LOCK:
  - `btn_press` clears the counter and sets cause=10.
  - `locked_s`=0 only clears the counter: no cause update, no count increment.
- `reset_cause` and `lock_loss_count` hold their values through RUN and are cleared only by `resetn`.
- Counter width: clog2 of the largest cycle parameter. Counts never wrap, because comparisons terminate each phase.

## Timing
- Edge numbering: edge 1 is the first rising edge with `resetn`=1. `pll_locked` is steady high throughout.
- `locked_s`=1 after edge `SYNC_STAGES`.
- `sys_reset` falls after edge `SYNC_STAGES`+`LOCK_STABLE_CYCLES`+`SYS_HOLD_CYCLES`.
- `periph_reset` falls and `ready` rises `PERIPH_DELAY_CYCLES` edges later.
- Abort latency, measured from the `pll_locked` fall to reset assertion: `SYNC_STAGES`+1 edges.
- Button latency: `SYNC_STAGES`+`DEBOUNCE_CYCLES`+1 edges from a clean rising edge.
- `resetn` asserted mid-sequence takes effect on the same edge it is sampled and overrides every event.
- `resetn` is sampled only on `clock`. If the PLL stops, the outputs hold, so downstream domains also gate on their own lock.

## Structure
- Shared package `reset_seq_pkg`:
  - state enum WAIT_LOCK/SYS_HOLD/PERIPH_HOLD/RUN;
  - cause constants CAUSE_POWER=2'b00, CAUSE_LOCK=2'b01, CAUSE_BUTTON=2'b10.
- One sub-module, `sync_debounce`:
  - parameters `SYNC_STAGES` and `DEBOUNCE_CYCLES`;
  - produces the synchronised level plus the one-shot press pulse;
  - instantiated for the button;
  - the `pll_locked` path uses it with `DEBOUNCE_CYCLES`=0, which gives a level output only.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `LOCK_STABLE_CYCLES`=8, `SYS_HOLD_CYCLES`=4, `PERIPH_DELAY_CYCLES`=4, `DEBOUNCE_CYCLES`=5.
- Clean power-up:
  - stimulus: `resetn` low 3 cycles then high, `pll_locked`=1;
  - required response: `sys_reset` falls after edge 14; `periph_reset` falls and `ready` rises after edge 18; cause=00.
- Lock glitch during WAIT_LOCK:
  - stimulus: `pll_locked` low for 1 cycle at counter 6;
  - required response: counter restarts and release is delayed by the lost cycles; cause stays 00; count=0.
- Lock loss in RUN:
  - stimulus: drop `pll_locked`;
  - required response: resets and `ready` change 3 edges later; cause=01; count=1; full sequence repeats on relock.
- Bouncing button:
  - stimulus: pulses of 3 cycles high, then 6 cycles high;
  - required response: only the 6-cycle pulse aborts; cause=10; a held button produces one abort only.
- Simultaneous lock loss and button press:
  - stimulus: both qualify on the same edge;
  - required response: cause=01; count increments.
- Saturation and reset override:
  - stimulus: 260 lock-loss events, then `resetn` asserted mid-SYS_HOLD;
  - required response: count sticks at 255; all outputs reach reset values on the next edge.
